// File: rtl/button_seq_checker_if.sv
// button_seq_checker_if: arm/button inputs and sequence-checker status outputs.
interface button_seq_checker_if;
    logic       arm;
    logic       btn_u;
    logic       btn_l;
    logic       btn_c;
    logic       btn_r;
    logic       btn_d;
    logic       press_valid;
    logic [2:0] press_code;
    logic [1:0] stage;
    logic [2:0] prompt;
    logic       err_pulse;
    logic       done;
    modport master (
        output arm, btn_u, btn_l, btn_c, btn_r, btn_d,
        input  press_valid, press_code, stage, prompt, err_pulse, done
    );
    modport slave (
        input  arm, btn_u, btn_l, btn_c, btn_r, btn_d,
        output press_valid, press_code, stage, prompt, err_pulse, done
    );
endinterface

// File: rtl/button_seq_checker.sv
// button_seq_checker: sync/debounce/edge-detect five buttons and check the D -> L -> R unlock sequence.
module button_seq_checker #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input logic clk,
    input logic rst_n,
    button_seq_checker_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT_D, WAIT_L, WAIT_R, DONE} state_e;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [4:0] raw, s1_q, s2_q, deb_q, deb_d, deb_dly_q, rel_q, rise;
    logic [1:0] fill_q;
    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] cnt_d [5];
    logic pv_q, amb_q, err_q, err_d, single, amb, ok;
    logic [2:0] code_q, code_d;
    state_e state_q, state_d;
    assign raw = {bus.btn_d, bus.btn_r, bus.btn_c, bus.btn_l, bus.btn_u};
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != deb_q[i]) begin
                cnt_d[i] = &cnt_q[i] ? cnt_q[i] : cnt_q[i] + 1'b1;
                if (cnt_q[i] >= CNT_LAST) begin
                    deb_d[i] = s2_q[i];
                    cnt_d[i] = '0;
                end
            end
        end
    end
    // a button must be seen released after reset before its rising edges count
    assign rise   = deb_q & ~deb_dly_q & rel_q;
    assign single = (rise != 5'd0) && ((rise & (rise - 5'd1)) == 5'd0);
    assign amb    = (rise != 5'd0) && !single;
    assign code_d = !single ? 3'd0 : rise[0] ? 3'd1 : rise[1] ? 3'd2 :
                    rise[2] ? 3'd3 : rise[3] ? 3'd4 : 3'd5;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            fill_q    <= '0;
            rel_q     <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
            pv_q      <= 1'b0;
            amb_q     <= 1'b0;
            code_q    <= '0;
            err_q     <= 1'b0;
            state_q   <= IDLE;
        end else begin
            s1_q      <= raw;
            s2_q      <= s1_q;
            fill_q    <= {fill_q[0], 1'b1};
            rel_q     <= rel_q | ({5{fill_q[1]}} & ~s2_q);
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
            pv_q      <= single;
            amb_q     <= amb;
            code_q    <= code_d;
            err_q     <= err_d;
            state_q   <= state_d;
        end
    end
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        ok      = 1'b0;
        if (!bus.arm) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = WAIT_D;
                WAIT_D, WAIT_L, WAIT_R: begin
                    ok = pv_q && code_q == (state_q == WAIT_D ? 3'd5 : state_q == WAIT_L ? 3'd2 : 3'd4);
                    if (pv_q || amb_q) begin
                        err_d   = !ok;
                        state_d = !ok ? WAIT_D : state_q == WAIT_D ? WAIT_L : state_q == WAIT_L ? WAIT_R : DONE;
                    end
                end
                DONE: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end
    assign bus.press_valid = pv_q;
    assign bus.press_code  = code_q;
    assign bus.err_pulse   = err_q;
    assign bus.done        = state_q == DONE;
    assign bus.stage  = state_q == WAIT_L ? 2'd1 : state_q == WAIT_R ? 2'd2 : state_q == DONE ? 2'd3 : 2'd0;
    assign bus.prompt = state_q == WAIT_D ? 3'd5 : state_q == WAIT_L ? 3'd2 : state_q == WAIT_R ? 3'd4 : 3'd0;
endmodule

// File: doc/button_seq_checker.md
Name: button_seq_checker

Overview:
- Input-side counterpart to the LED-fill / 7-seg prompt logic in top.
- Conditions the five raw push-buttons with synchronisation, debounce and rising-edge detection.
- Checks that the user enters the unlock sequence D -> L -> R once armed.
- Outputs the current stage and the expected-button prompt code for the 7-seg driver, plus a sticky done flag that drives maxled.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronised button level must differ from its debounced level before it is accepted (10 ms at 100 MHz).
- CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  level; high = sequence entry enabled (driven by the LED-fill-complete condition).
- btnU, btnL, btnC, btnR, btnD  in  1 each  raw asynchronous push-buttons, active-high.
- press_valid  out  1  one-cycle pulse when exactly one debounced button rising edge occurs.
- press_code  out  3  button code, valid while press_valid=1, else 0. Codes: 0 none, 1 U, 2 L, 3 C, 4 R, 5 D.
- stage  out  2  0 IDLE/WAIT_D, 1 WAIT_L, 2 WAIT_R, 3 DONE.
- prompt  out  3  code of the button expected next (5, 2, 4); 0 in IDLE and DONE.
- err_pulse  out  1  one-cycle pulse on a wrong or ambiguous press while armed.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst_n=0, async):
  - All sync flops, debounced levels and counters clear to 0.
  - FSM goes to IDLE.
  - press_valid=0, press_code=0, err_pulse=0, done=0, stage=0, prompt=0.
- Synchroniser: two flops per button. The raw-to-sync latency is 2 cycles.
- Debounce, per button, independent:
  - If sync != deb, the counter increments; otherwise the counter is cleared to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while sync != deb, deb takes the sync value on that edge and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles never changes deb.
  - The counter saturates; it never wraps.
- Edge detect: rise = deb & ~deb_q (deb_q is deb delayed one cycle).
  - Exactly one rise bit set: press_valid=1 and press_code=that code on the next cycle (registered).
  - Two or more rise bits set in the same cycle: no press_valid. err_pulse fires instead if the FSM is armed and not in DONE.
  - Releases (falling edges) are ignored.
- FSM is registered and acts on the same cycle press_valid is asserted.
  - IDLE: stage=0, prompt=0. Go to WAIT_D when arm=1; presses in IDLE are ignored with no error.
  - WAIT_D: prompt=5. A D press goes to WAIT_L. Any other press, or an ambiguous press, raises err_pulse and stays in WAIT_D.
  - WAIT_L: prompt=2. An L press goes to WAIT_R. Otherwise err_pulse and return to WAIT_D.
  - WAIT_R: prompt=4. An R press goes to DONE. Otherwise err_pulse and return to WAIT_D.
  - DONE: stage=3, done=1, prompt=0. Further presses are ignored with no error. DONE is sticky until arm=0 or reset.
  - arm=0 in any state forces IDLE on the next edge. This takes priority over a simultaneous press.
- Held buttons: a button already held when arm rises does not count. Only a new debounced rising edge counts.
- Total latency:
  - Raw press to press_valid = 2 + DEBOUNCE_CYCLES + 1 cycles.
  - stage update = press_valid cycle + 1.
- Mid-operation reset: an async return to the reset state at once, with no pending press retained.

Test Plan:
- Set DEBOUNCE_CYCLES=4 in all tests.
- Reset/idle: rst_n low, then high with arm=0; pulse btnD clean for 20 cycles -> press_valid pulses with code 5; stage stays 0, err_pulse=0, done=0.
- Debounce: with arm=1, btnD high for 3 cycles then low -> no press_valid. btnD held 10 cycles -> exactly one press_valid with code 5, asserted 7 cycles after the raw rise, and stage=1 one cycle later.
- Correct sequence: arm=1; clean D, L, R presses, each 10 cycles with 10-cycle gaps -> stage goes 0->1->2->3, prompt goes 5->2->4->0, done=1. A further U press -> press_valid with code 1, no err_pulse, stage stays 3.
- Wrong and ambiguous presses:
  - D then C -> err_pulse one cycle, stage back to 0.
  - L and R rising in the same cycle while in WAIT_L -> err_pulse, no press_valid, stage back to 0.
- Arm drop / async reset: reach stage=2, drop arm -> stage=0 next edge. Re-arm and reach DONE, then assert rst_n=0 mid-press -> all outputs 0 immediately. The held button after release of reset produces no press until it is re-pressed.
